// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the pseudo-LRU replacement array.
// Node n of a binary tree has children 2n+1 (lower ways) and 2n+2 (upper ways).
package plru_pkg;

   typedef enum logic {
      PLRU_IDLE  = 1'b0,
      PLRU_FLUSH = 1'b1
   } plru_state_e;

   function automatic int plru_parent(input int node);
      return (node - 1) / 2;
   endfunction

   function automatic int plru_child(input int node, input logic dir);
      return 2 * node + 1 + int'(dir);
   endfunction

   function automatic int plru_leaf_node(input int way, input int ways);
      return way + ways - 1;
   endfunction

   function automatic int plru_leaf_way(input int node, input int ways);
      return node - (ways - 1);
   endfunction

endpackage

// File: rtl/plru_tree_victim.sv
// Combinational victim selection from one set's tree bits plus the per-way
// valid and lock masks.
module plru_tree_victim
   import plru_pkg::*;
#(
   parameter int SET_ASSOC = 4
) (
   input  logic [SET_ASSOC-2:0]         tree_bits,
   input  logic [SET_ASSOC-1:0]         valid,
   input  logic [SET_ASSOC-1:0]         lock,
   output logic [$clog2(SET_ASSOC)-1:0] vic_way,
   output logic                         vic_none
);

   localparam int WAY_W = $clog2(SET_ASSOC);
   localparam int NODES = SET_ASSOC - 1;
   localparam int ALL_N = 2 * SET_ASSOC - 1;

   logic [ALL_N-1:0] on_path;
   logic [WAY_W-1:0] tree_way;
   logic [WAY_W-1:0] first_free;
   logic [WAY_W-1:0] first_unlocked;
   logic             free_found;
   logic             unlocked_found;

   // Walk is expressed per node with fixed indices, so no variable selects.
   always_comb begin
      on_path    = '0;
      on_path[0] = 1'b1;
      for (int n = 0; n < NODES; n++) begin
         on_path[plru_child(n, 1'b0)] = on_path[n] & ~tree_bits[n];
         on_path[plru_child(n, 1'b1)] = on_path[n] &  tree_bits[n];
      end
      tree_way = '0;
      for (int l = 0; l < SET_ASSOC; l++) begin
         if (on_path[plru_leaf_node(l, SET_ASSOC)]) begin
            tree_way = WAY_W'(l);
         end
      end
   end

   always_comb begin
      free_found     = 1'b0;
      unlocked_found = 1'b0;
      first_free     = '0;
      first_unlocked = '0;
      for (int i = 0; i < SET_ASSOC; i++) begin
         if (!free_found && !valid[i] && !lock[i]) begin
            free_found = 1'b1;
            first_free = WAY_W'(i);
         end
         if (!unlocked_found && !lock[i]) begin
            unlocked_found = 1'b1;
            first_unlocked = WAY_W'(i);
         end
      end
   end

   always_comb begin
      vic_way  = tree_way;
      vic_none = 1'b0;
      if (free_found) begin
         vic_way = first_free;
      end else if (!lock[tree_way]) begin
         vic_way = tree_way;
      end else if (unlocked_found) begin
         vic_way = first_unlocked;
      end else begin
         vic_none = 1'b1;
      end
   end

endmodule

// File: rtl/plru_array.sv
// Tree pseudo-LRU state for NUM_SETS sets with a one-cycle victim lookup
// and a sequential flush walk.
//
//   state      | meaning
//   PLRU_IDLE  | updates and lookups accepted; flush pulse starts the walk
//   PLRU_FLUSH | clearing one set per cycle from index 0; lookups/updates blocked
module plru_array
   import plru_pkg::*;
#(
   parameter int SET_ASSOC = 4,
   parameter int NUM_SETS  = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         upd_en,
   input  logic [$clog2(NUM_SETS)-1:0]  upd_idx,
   input  logic [$clog2(SET_ASSOC)-1:0] upd_way,
   input  logic                         lkp_req,
   input  logic [$clog2(NUM_SETS)-1:0]  lkp_idx,
   input  logic [SET_ASSOC-1:0]         lkp_valid,
   input  logic [SET_ASSOC-1:0]         lkp_lock,
   output logic                         lkp_ready,
   output logic                         vic_valid,
   output logic [$clog2(SET_ASSOC)-1:0] vic_way,
   output logic                         vic_none,
   input  logic                         flush,
   output logic                         flush_busy
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(SET_ASSOC);
   localparam int NODES = SET_ASSOC - 1;
   localparam int ALL_N = 2 * SET_ASSOC - 1;

   plru_state_e                    state_q, state_d;
   logic [IDX_W-1:0]               flush_cnt_q, flush_cnt_d;
   logic [NUM_SETS-1:0][NODES-1:0] tree_q, tree_d;
   logic                           vic_valid_q, vic_valid_d;
   logic [WAY_W-1:0]               vic_way_q, vic_way_d;
   logic                           vic_none_q, vic_none_d;

   logic             upd_acc;
   logic             lkp_acc;
   logic [NODES-1:0] upd_bits;
   logic [NODES-1:0] lkp_bits;
   logic [WAY_W-1:0] sel_way;
   logic             sel_none;

   // Every node on the path to the accessed leaf points into the other subtree.
   function automatic logic [NODES-1:0] tree_update(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
      logic [ALL_N-1:0] hit;
      logic [NODES-1:0] nb;
      hit = '0;
      nb  = bits;
      for (int l = 0; l < SET_ASSOC; l++) begin
         hit[plru_leaf_node(l, SET_ASSOC)] = (way == WAY_W'(l));
      end
      for (int n = NODES - 1; n >= 0; n--) begin
         hit[n] = hit[plru_child(n, 1'b0)] | hit[plru_child(n, 1'b1)];
         if (hit[n]) begin
            nb[n] = hit[plru_child(n, 1'b0)];
         end
      end
      return nb;
   endfunction

   assign lkp_ready  = (state_q == PLRU_IDLE);
   assign flush_busy = (state_q == PLRU_FLUSH);

   assign upd_acc  = upd_en && (state_q == PLRU_IDLE) && !flush;
   assign lkp_acc  = lkp_req && lkp_ready;
   assign upd_bits = tree_update(tree_q[upd_idx], upd_way);
   // Same-set update forwards into the lookup so it sees the post-update tree.
   assign lkp_bits = (upd_acc && (upd_idx == lkp_idx)) ? upd_bits : tree_q[lkp_idx];

   plru_tree_victim #(
      .SET_ASSOC (SET_ASSOC)
   ) u_victim (
      .tree_bits (lkp_bits),
      .valid     (lkp_valid),
      .lock      (lkp_lock),
      .vic_way   (sel_way),
      .vic_none  (sel_none)
   );

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      tree_d      = tree_q;
      case (state_q)
         PLRU_IDLE: begin
            if (flush) begin
               state_d     = PLRU_FLUSH;
               flush_cnt_d = '0;
            end else if (upd_acc) begin
               tree_d[upd_idx] = upd_bits;
            end
         end
         PLRU_FLUSH: begin
            tree_d[flush_cnt_q] = '0;
            flush_cnt_d         = flush_cnt_q + 1'b1;
            if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) begin
               state_d = PLRU_IDLE;
            end
         end
         default: begin
            state_d = PLRU_IDLE;
         end
      endcase
   end

   always_comb begin
      vic_valid_d = lkp_acc;
      vic_way_d   = vic_way_q;
      vic_none_d  = vic_none_q;
      if (lkp_acc) begin
         vic_way_d  = sel_way;
         vic_none_d = sel_none;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PLRU_IDLE;
         flush_cnt_q <= '0;
         tree_q      <= '0;
         vic_valid_q <= 1'b0;
         vic_way_q   <= '0;
         vic_none_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         tree_q      <= tree_d;
         vic_valid_q <= vic_valid_d;
         vic_way_q   <= vic_way_d;
         vic_none_q  <= vic_none_d;
      end
   end

   assign vic_valid = vic_valid_q;
   assign vic_way   = vic_way_q;
   assign vic_none  = vic_none_q;

endmodule
